// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level bit meanings.
// Kept separate so the initiator side can import the same constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Open-drain I2C pad bundle as seen by a target: raw SCL/SDA in, SDA pull-down out.
interface i2c_target_if;

    logic scl_in;
    logic sda_in;
    logic sda_enable;

    modport master (output scl_in, output sda_in, input sda_enable);
    modport slave  (input scl_in, input sda_in, output sda_enable);

endinterface

// File: rtl/i2c_line_monitor.sv
// Synchronises raw SCL/SDA and derives SCL edges and START/STOP conditions.
module i2c_line_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_sync,
    output logic start_det,
    output logic stop_det
);

    // [0] metastability stage, [1] synchronised level, [2] one-clk delayed level
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;
    logic       scl_s, scl_dly, sda_s, sda_dly;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_in};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
    end

    // Pipelines reset to the idle-bus level so reset release creates no events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe_q <= '1;
            sda_pipe_q <= '1;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    always_comb begin
        scl_s     = scl_pipe_q[1];
        scl_dly   = scl_pipe_q[2];
        sda_s     = sda_pipe_q[1];
        sda_dly   = sda_pipe_q[2];
        scl_rise  = scl_s & ~scl_dly;
        scl_fall  = ~scl_s & scl_dly;
        sda_sync  = sda_s;
        start_det = scl_s & scl_dly & sda_dly & ~sda_s;
        stop_det  = scl_s & scl_dly & ~sda_dly & sda_s;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with a small register bank: first written byte sets the pointer,
// later bytes write/read the bank with auto-increment. No clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h2F,
    parameter int unsigned NUM_REGS    = 4,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                        clk,
    input  logic                        reset_n,
    i2c_target_if.slave                 bus,
    output logic [8*NUM_REGS-1:0]       regs_flat,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic [7:0]                  wr_data,
    output logic                        busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [1:0] rst_pipe_q, rst_pipe_d;
    logic       rst_n_int;

    always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe_q <= '0;
        else          rst_pipe_q <= rst_pipe_d;
    end

    assign rst_n_int = rst_pipe_q[1];

    logic scl_rise, scl_fall, sda_sync, start_det, stop_det;

    i2c_line_monitor u_mon (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_sync  (sda_sync),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic             phase_q, phase_d;
    logic             first_q, first_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic             sda_en_q, sda_en_d;
    logic             busy_q, busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [IDX_W-1:0] wr_index_q, wr_index_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       sampled;
    logic [7:0]       rd_byte;

    // phase_q: in *_ACK states, set once the ACK slot is being driven;
    // in RD_ACK, set once the initiator has ACKed and the next byte is due.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        first_d     = first_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        sda_en_d    = sda_en_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        sampled     = {shift_q[6:0], sda_sync};
        rd_byte     = regs_q[ptr_q];

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_en_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_en_d  = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = sampled;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (sampled[7:1] == TARGET_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sampled[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_en_d = 1'b1;
                            busy_d   = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            if (rw_q == RW_READ) begin
                                shift_d  = rd_byte;
                                sda_en_d = ~rd_byte[7];
                                state_d  = ST_RD_BYTE;
                            end else begin
                                sda_en_d = 1'b0;
                                first_d  = 1'b1;
                                state_d  = ST_WR_BYTE;
                            end
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = sampled;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (first_q) begin
                                ptr_d   = sampled[IDX_W-1:0];
                                first_d = 1'b0;
                            end else begin
                                regs_d[ptr_q] = sampled;
                                wr_strobe_d   = 1'b1;
                                wr_index_d    = ptr_q;
                                wr_data_d     = sampled;
                                ptr_d         = ptr_q + 1'b1;
                            end
                            state_d = ST_WR_ACK;
                            phase_d = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_en_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_en_d  = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_WR_BYTE;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    // bit 7 went out on entry; falls 1..7 drive bits 6..0, fall 8 releases
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_en_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_en_d = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_sync == ACK) begin
                            ptr_d   = ptr_q + 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && phase_q) begin
                        shift_d   = rd_byte;
                        sda_en_d  = ~rd_byte[7];
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        state_d   = ST_RD_BYTE;
                    end
                end
                ST_WAIT_STOP: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= RW_WRITE;
            phase_q     <= 1'b0;
            first_q     <= 1'b0;
            ptr_q       <= '0;
            sda_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            first_q     <= first_d;
            ptr_q       <= ptr_d;
            sda_en_q    <= sda_en_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs_q[i];
    end

    assign bus.sda_enable = sda_en_q;
    assign wr_strobe      = wr_strobe_q;
    assign wr_index       = wr_index_q;
    assign wr_data        = wr_data_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C initiator with an open-drain SDA model.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 100;  // quarter SCL period = 10 clk

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        scl;
    logic        sda_m;
    logic [31:0] regs_flat;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic [7:0]  wr_data;
    logic        busy;

    i2c_target_if bus ();
    assign bus.scl_in = scl;
    assign bus.sda_in = sda_m & ~bus.sda_enable;

    i2c_target #(
        .TARGET_ADDR (7'h2F),
        .NUM_REGS    (4),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int compared   = 0;
    int mismatched = 0;

    int         stb_cnt  = 0;
    int         sda_cnt  = 0;
    int         busy_cnt = 0;
    int         stb_idx [32];
    logic [7:0] stb_dat [32];

    always @(negedge clk) begin
        if (wr_strobe) begin
            if (stb_cnt < 32) begin
                stb_idx[stb_cnt] = int'(wr_index);
                stb_dat[stb_cnt] = wr_data;
            end
            stb_cnt++;
        end
        if (bus.sda_enable) sda_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic line);
        sda_m = b;
        #(Q); scl = 1'b1;
        #(Q); line = bus.sda_in;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); sda_m = 1'b0;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); sda_m = 1'b1;
        #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ackbit);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ackbit);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic ackline);
        logic bitv;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, bitv);
            d[i] = bitv;
        end
        send_bit(mack, ackline);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] data;
        int         exp_idx;
        logic [7:0] exp_reg;
    } wr_vec_t;

    wr_vec_t vecs [4];

    initial begin
        logic       a;
        logic       line;
        logic [7:0] d;
        int         base;
        int         sbase;
        int         bbase;

        vecs[0] = '{ptr: 8'h07, data: 8'h44, exp_idx: 3, exp_reg: 8'h44};
        vecs[1] = '{ptr: 8'h02, data: 8'h99, exp_idx: 2, exp_reg: 8'h99};
        vecs[2] = '{ptr: 8'h04, data: 8'h5A, exp_idx: 0, exp_reg: 8'h5A};
        vecs[3] = '{ptr: 8'hFD, data: 8'hC3, exp_idx: 1, exp_reg: 8'hC3};

        scl = 1'b1; sda_m = 1'b1; reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_enable", bus.sda_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_index", wr_index, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_regs", regs_flat, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // write ptr 1, then A5, 3C
        base = stb_cnt;
        start_cond();
        send_byte(8'h5E, a); check("t1_addr_ack", a, ACK);
        send_byte(8'h01, a); check("t1_ptr_ack", a, ACK);
        send_byte(8'hA5, a); check("t1_d0_ack", a, ACK);
        send_byte(8'h3C, a); check("t1_d1_ack", a, ACK);
        check("t1_busy_before_stop", busy, 1);
        stop_cond();
        #(Q);
        check("t1_busy_after_stop", busy, 0);
        check("t1_regs", regs_flat, 32'h003C_A500);
        check("t1_strobes", stb_cnt - base, 2);
        check("t1_stb0_idx", stb_idx[base], 1);
        check("t1_stb0_dat", stb_dat[base], 8'hA5);
        check("t1_stb1_idx", stb_idx[base + 1], 2);
        check("t1_stb1_dat", stb_dat[base + 1], 8'h3C);
        check("t1_wr_index_hold", wr_index, 2);
        check("t1_wr_data_hold", wr_data, 8'h3C);

        // wrong address 0x2E
        base = stb_cnt; sbase = sda_cnt; bbase = busy_cnt;
        start_cond();
        send_byte(8'h5C, a); check("t2_addr_nack", a, NACK);
        send_byte(8'h77, a); check("t2_data_nack", a, NACK);
        stop_cond();
        #(Q);
        check("t2_sda_never", sda_cnt - sbase, 0);
        check("t2_busy_never", busy_cnt - bbase, 0);
        check("t2_no_strobe", stb_cnt - base, 0);
        check("t2_regs", regs_flat, 32'h003C_A500);

        // pointer write, repeated START, read 3 bytes
        start_cond();
        send_byte(8'h5E, a); check("t3_addr_ack", a, ACK);
        send_byte(8'h01, a); check("t3_ptr_ack", a, ACK);
        start_cond();
        send_byte(8'h5F, a); check("t3_raddr_ack", a, ACK);
        read_byte(ACK, d, line);  check("t3_rd0", d, 8'hA5);
        read_byte(ACK, d, line);  check("t3_rd1", d, 8'h3C);
        read_byte(NACK, d, line); check("t3_rd2", d, 8'h00);
        check("t3_nack_line_released", line, 1);
        check("t3_busy_after_nack", busy, 0);
        check("t3_sda_after_nack", bus.sda_enable, 0);
        sbase = sda_cnt;
        send_bit(1'b0, line);
        send_bit(1'b0, line);
        check("t3_wait_stop_quiet", sda_cnt - sbase, 0);
        stop_cond();
        #(Q);

        // pointer wrap on write
        base = stb_cnt;
        start_cond();
        send_byte(8'h5E, a); check("t4_addr_ack", a, ACK);
        send_byte(8'h03, a); check("t4_ptr_ack", a, ACK);
        send_byte(8'h11, a); check("t4_d0_ack", a, ACK);
        send_byte(8'h22, a); check("t4_d1_ack", a, ACK);
        stop_cond();
        #(Q);
        check("t4_regs", regs_flat, 32'h113C_A522);
        check("t4_stb0_idx", stb_idx[base], 3);
        check("t4_stb1_idx", stb_idx[base + 1], 0);

        // single-byte writes; pointer byte reduced mod 4
        for (int v = 0; v < 4; v++) begin
            base = stb_cnt;
            start_cond();
            send_byte(8'h5E, a);         check($sformatf("vec%0d_addr_ack", v), a, ACK);
            send_byte(vecs[v].ptr, a);   check($sformatf("vec%0d_ptr_ack", v), a, ACK);
            send_byte(vecs[v].data, a);  check($sformatf("vec%0d_data_ack", v), a, ACK);
            stop_cond();
            #(Q);
            check($sformatf("vec%0d_strobes", v), stb_cnt - base, 1);
            check($sformatf("vec%0d_idx", v), stb_idx[base], vecs[v].exp_idx);
            check($sformatf("vec%0d_dat", v), stb_dat[base], vecs[v].data);
            check($sformatf("vec%0d_reg", v), regs_flat[8*vecs[v].exp_idx +: 8], vecs[v].exp_reg);
        end
        check("vec_regs_all", regs_flat, 32'h4499_C35A);

        // STOP after 4 data bits
        base = stb_cnt;
        start_cond();
        send_byte(8'h5E, a); check("t5_addr_ack", a, ACK);
        send_byte(8'h02, a); check("t5_ptr_ack", a, ACK);
        send_bit(1'b1, line); send_bit(1'b0, line);
        send_bit(1'b1, line); send_bit(1'b0, line);
        stop_cond();
        #(Q);
        check("t5_no_strobe", stb_cnt - base, 0);
        check("t5_regs_kept", regs_flat, 32'h4499_C35A);
        check("t5_busy", busy, 0);
        start_cond();
        send_byte(8'h5E, a); check("t5_next_addr_ack", a, ACK);
        send_byte(8'h02, a); check("t5_next_ptr_ack", a, ACK);
        send_byte(8'h77, a); check("t5_next_data_ack", a, ACK);
        stop_cond();
        #(Q);
        check("t5_next_strobes", stb_cnt - base, 1);
        check("t5_next_regs", regs_flat, 32'h4477_C35A);

        // reset asserted while the address ACK is being driven
        start_cond();
        for (int i = 7; i >= 0; i--) begin
            d = 8'h5E;
            send_bit(d[i], line);
        end
        check("t6_ack_driven", bus.sda_enable, 1);
        check("t6_busy_set", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t6_sda_async_drop", bus.sda_enable, 0);
        check("t6_busy_drop", busy, 0);
        check("t6_regs_reset", regs_flat, 32'h0);
        repeat (3) @(posedge clk);
        reset_n = 1'b1;
        sda_m = 1'b1;
        #(Q); scl = 1'b1;
        #(Q);
        check("t6_idle_after_reset", bus.sda_enable, 0);
        base = stb_cnt;
        start_cond();
        send_byte(8'h5E, a); check("t6_addr_ack", a, ACK);
        send_byte(8'h00, a); check("t6_ptr_ack", a, ACK);
        send_byte(8'h42, a); check("t6_data_ack", a, ACK);
        stop_cond();
        #(Q);
        check("t6_regs", regs_flat, 32'h0000_0042);
        check("t6_strobe_idx", stb_idx[base], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
